// File: rtl/prince_pkg.sv
// Shared types and constants for the masked PRINCE I/O controller.
// Holds the FSM state encoding, request/result bundles and the default timeout.
package prince_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } prince_state_e;

    // Default maximum number of RUN cycles before an operation is aborted.
    localparam int unsigned PRINCE_TIMEOUT = 63;

    localparam int unsigned PRINCE_BLK_W = 64;
    localparam int unsigned PRINCE_KEY_W = 128;

    // Registered request: the two plaintext shares, key and direction.
    typedef struct packed {
        logic                    enc;
        logic [PRINCE_BLK_W-1:0] p0;
        logic [PRINCE_BLK_W-1:0] p1;
        logic [PRINCE_KEY_W-1:0] key;
    } prince_req_t;

    // Registered result: the two output shares and the abort flag.
    typedef struct packed {
        logic                    err;
        logic [PRINCE_BLK_W-1:0] c0;
        logic [PRINCE_BLK_W-1:0] c1;
    } prince_res_t;

    // Counter width able to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/prince_timeout_cnt.sv
// Saturating RUN-cycle counter with a hit flag at MAX_CNT.
// Ports: clk, rst (sync, active-high), clr_i (zero), en_i (count), hit_o (cnt == MAX_CNT).
module prince_timeout_cnt
    import prince_pkg::*;
#(
    parameter int unsigned MAX_CNT = PRINCE_TIMEOUT,
    parameter int unsigned CNT_W   = cnt_width(MAX_CNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority; counting stops once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + ONE_V;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == MAX_V);

endmodule

// File: rtl/prince_io_ctrl.sv
// Request/response wrapper around a masked PRINCE core: shares the input,
// sequences reset/enable of the core, and captures its output shares.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             request handshake
//   in_enc, in_pt, in_mask, in_key request fields (mask = sharing randomness)
//   core_rst, core_en, core_enc   core control
//   core_p0, core_p1, core_k      registered shares and key to the core
//   core_done, core_c0, core_c1   core completion strobe and output shares
//   out_valid/out_ready           result handshake
//   out_c0, out_c1, out_err       captured shares and timeout flag
module prince_io_ctrl
    import prince_pkg::*;
#(
    parameter int unsigned TIMEOUT = PRINCE_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_enc,
    input  logic [63:0]  in_pt,
    input  logic [63:0]  in_mask,
    input  logic [127:0] in_key,

    output logic         core_rst,
    output logic         core_en,
    output logic         core_enc,
    output logic [63:0]  core_p0,
    output logic [63:0]  core_p1,
    output logic [127:0] core_k,
    input  logic         core_done,
    input  logic [63:0]  core_c0,
    input  logic [63:0]  core_c1,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_c0,
    output logic [63:0]  out_c1,
    output logic         out_err
);

    prince_state_e state_q;
    prince_state_e state_d;

    prince_req_t   req_q;
    prince_req_t   req_d;
    prince_res_t   res_q;
    prince_res_t   res_d;

    logic accept;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_hit;

    prince_timeout_cnt #(
        .MAX_CNT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .hit_o (cnt_hit)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                if (core_done || cnt_hit) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request registers: the plaintext is split into two shares on accept
    // so the unmasked value never reaches the core ports.
    // ------------------------------------------------------------------
    always_comb begin
        req_d = req_q;
        if (accept) begin
            req_d.enc = in_enc;
            req_d.p0  = in_pt ^ in_mask;
            req_d.p1  = in_mask;
            req_d.key = in_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: shares are captured separately, never recombined.
    // A done strobe in the timeout cycle still counts as a success.
    // ------------------------------------------------------------------
    always_comb begin
        res_d = res_q;
        if (state_q == RUN) begin
            if (core_done) begin
                res_d.err = 1'b0;
                res_d.c0  = core_c0;
                res_d.c1  = core_c1;
            end else if (cnt_hit) begin
                res_d.err = 1'b1;
                res_d.c0  = '0;
                res_d.c1  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all state- or register-driven. The core reset also follows
    // the system reset directly so an aborted run is cleared immediately.
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);

    assign core_rst  = rst | (state_q == LOAD);
    assign core_en   = (state_q == RUN) & ~rst;
    assign core_enc  = req_q.enc;
    assign core_p0   = req_q.p0;
    assign core_p1   = req_q.p1;
    assign core_k    = req_q.key;

    assign out_c0    = res_q.c0;
    assign out_c1    = res_q.c1;
    assign out_err   = res_q.err;

endmodule

// File: tb/tb_prince_io_ctrl.sv
// Self-checking bench for prince_io_ctrl with a table-driven core stub.
// Expected results are queued on request and compared when out_valid rises.
module tb_prince_io_ctrl;

    localparam int TO = 63;

    typedef struct {
        logic [63:0] c;
        logic        err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_enc;
    logic [63:0]  in_pt;
    logic [63:0]  in_mask;
    logic [127:0] in_key;
    logic         core_rst;
    logic         core_en;
    logic         core_enc;
    logic [63:0]  core_p0;
    logic [63:0]  core_p1;
    logic [127:0] core_k;
    logic         core_done;
    logic [63:0]  core_c0;
    logic [63:0]  core_c1;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_c0;
    logic [63:0]  out_c1;
    logic         out_err;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    logic [63:0]  cur_p0;
    logic [63:0]  cur_p1;
    logic [127:0] cur_k;
    logic         cur_enc;

    always #5 clk = ~clk;

    prince_io_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_enc    (in_enc),
        .in_pt     (in_pt),
        .in_mask   (in_mask),
        .in_key    (in_key),
        .core_rst  (core_rst),
        .core_en   (core_en),
        .core_enc  (core_enc),
        .core_p0   (core_p0),
        .core_p1   (core_p1),
        .core_k    (core_k),
        .core_done (core_done),
        .core_c0   (core_c0),
        .core_c1   (core_c1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c0    (out_c0),
        .out_c1    (out_c1),
        .out_err   (out_err)
    );

    // Core stub: known PRINCE vectors for a zero key, otherwise an
    // arbitrary keyed mix; output is re-shared with fresh randomness.
    function automatic logic [63:0] model(input logic [63:0] x,
                                          input logic [127:0] k,
                                          input logic e);
        if (e && x == 64'h0 && k == 128'h0)
            return 64'h818665AA0D02DFDA;
        if (!e && x == 64'h818665AA0D02DFDA && k == 128'h0)
            return 64'h0;
        return x ^ k[63:0] ^ {k[31:0], k[127:96]} ^
               (e ? 64'h5A5A_0F0F_3C3C_A5A5 : 64'hC3C3_9696_F0F0_1234);
    endfunction

    int          stub_lat   = 0;
    bit          stub_never = 1'b0;
    logic        force_done = 1'b0;
    int          sc = 0;
    logic [63:0] sr = 64'h0;

    always @(posedge clk) begin
        if (core_rst) begin
            sc <= 0;
            sr <= {$urandom, $urandom};
        end else if (core_en) begin
            sc <= sc + 1;
        end
    end

    assign core_done = force_done |
        (core_en & ~stub_never & (sc == stub_lat));
    assign core_c0 = model(core_p0 ^ core_p1, core_k, core_enc) ^ sr;
    assign core_c1 = sr;

    // Drive one request (call at a negedge in IDLE) and queue its result.
    task automatic send(input logic e, input logic [63:0] pt,
                        input logic [63:0] mask, input logic [127:0] k,
                        input bit to);
        exp_t x;
        in_valid = 1'b1;
        in_enc   = e;
        in_pt    = pt;
        in_mask  = mask;
        in_key   = k;
        cur_p0   = pt ^ mask;
        cur_p1   = mask;
        cur_k    = k;
        cur_enc  = e;
        x.err    = to;
        x.c      = to ? 64'h0 : model(pt, k, e);
        exp_q.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, counting RUN cycles and tracking
    // whether the core inputs stayed equal to the accepted request.
    task automatic wait_out(input int budget, output int n_run,
                            output bit seen, output bit stable);
        n_run  = 0;
        seen   = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (core_en === 1'b1) n_run++;
            if (core_p0 !== cur_p0 || core_p1 !== cur_p1 ||
                core_k !== cur_k || core_enc !== cur_enc)
                stable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_enc = 1'b0;
        in_pt = '0;
        in_mask = '0;
        in_key = '0;
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b1) begin
            errors++;
            $display("FAIL rst_core_rst: got %b want 1", core_rst);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (core_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_core_en: got %b want 0", core_en);
        end
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_flags: got valid=%b err=%b want 0 0",
                     out_valid, out_err);
        end
        checks++;
        if (out_c0 !== 64'h0 || out_c1 !== 64'h0) begin
            errors++;
            $display("FAIL rst_out_shares: got %h %h want 0 0", out_c0, out_c1);
        end
        checks++;
        if (core_p0 !== 64'h0 || core_p1 !== 64'h0 || core_k !== 128'h0 ||
            core_enc !== 1'b0) begin
            errors++;
            $display("FAIL rst_core_regs: got p0=%h p1=%h k=%h enc=%b want 0",
                     core_p0, core_p1, core_k, core_enc);
        end
        checks++;
        if (core_rst !== 1'b0) begin
            errors++;
            $display("FAIL rst_core_rst_idle: got %b want 0", core_rst);
        end
    endtask

    task automatic test_encrypt_vector();
        int   n;
        bit   seen;
        bit   stab;
        exp_t x;
        stub_never = 1'b0;
        stub_lat   = 5;
        send(1'b1, 64'h0, 64'h0123456789ABCDEF, 128'h0, 1'b0);
        checks++;
        if (core_rst !== 1'b1 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL enc_load: got rst=%b en=%b want 1 0", core_rst, core_en);
        end
        wait_out(TO + 20, n, seen, stab);
        x = exp_q.pop_front();
        checks++;
        if (!seen || n != stub_lat + 1) begin
            errors++;
            $display("FAIL enc_latency: got seen=%b run=%0d want 1 %0d",
                     seen, n, stub_lat + 1);
        end
        checks++;
        if ((out_c0 ^ out_c1) !== x.c || out_err !== x.err) begin
            errors++;
            $display("FAIL enc_result: got %h err=%b want %h err=%b",
                     out_c0 ^ out_c1, out_err, x.c, x.err);
        end
        checks++;
        if (out_c1 !== sr) begin
            errors++;
            $display("FAIL enc_share1: got %h want %h", out_c1, sr);
        end
        checks++;
        if (!stab) begin
            errors++;
            $display("FAIL enc_core_inputs: got unstable want stable");
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL enc_release: got valid=%b ready=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_decrypt_vector();
        int   n;
        bit   seen;
        bit   stab;
        exp_t x;
        stub_never = 1'b0;
        stub_lat   = 9;
        send(1'b0, 64'h818665AA0D02DFDA, 64'h0123456789ABCDEF, 128'h0, 1'b0);
        wait_out(TO + 20, n, seen, stab);
        x = exp_q.pop_front();
        checks++;
        if (!seen || (out_c0 ^ out_c1) !== x.c || out_err !== 1'b0) begin
            errors++;
            $display("FAIL dec_result: got seen=%b %h err=%b want %h err=0",
                     seen, out_c0 ^ out_c1, out_err, x.c);
        end
        checks++;
        if (!stab || core_p1 !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL dec_p1_mask: got stable=%b p1=%h want 1 %h",
                     stab, core_p1, 64'h0123456789ABCDEF);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int   n;
        bit   seen;
        bit   stab;
        exp_t x;
        stub_never = 1'b1;
        send(1'b1, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        wait_out(TO + 20, n, seen, stab);
        x = exp_q.pop_front();
        checks++;
        if (!seen || n != TO + 1) begin
            errors++;
            $display("FAIL to_latency: got seen=%b run=%0d want 1 %0d",
                     seen, n, TO + 1);
        end
        checks++;
        if (out_err !== x.err) begin
            errors++;
            $display("FAIL to_err: got %b want %b", out_err, x.err);
        end
        checks++;
        if (out_c0 !== 64'h0 || out_c1 !== 64'h0) begin
            errors++;
            $display("FAIL to_shares: got %h %h want 0 0", out_c0, out_c1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        stub_never = 1'b0;
    endtask

    task automatic test_hold_stall();
        int          n;
        bit          seen;
        bit          stab;
        exp_t        x;
        logic [63:0] c0s;
        logic [63:0] c1s;
        stub_lat = 3;
        send(1'b1, 64'hDEADBEEF_CAFEF00D, 64'h1122334455667788,
             128'h0F0E0D0C0B0A09080706050403020100, 1'b0);
        wait_out(TO + 20, n, seen, stab);
        x = exp_q.pop_front();
        checks++;
        if (!seen || (out_c0 ^ out_c1) !== x.c || out_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_result: got seen=%b %h err=%b want %h err=0",
                     seen, out_c0 ^ out_c1, out_err, x.c);
        end
        c0s = out_c0;
        c1s = out_c1;
        in_valid   = 1'b1;
        in_pt      = 64'hFFFF_0000_FFFF_0000;
        in_mask    = 64'h1234_5678_9ABC_DEF0;
        in_key     = '1;
        force_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_c0 !== c0s || out_c1 !== c1s) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b r=%b %h %h want 1 0 %h %h",
                         i, out_valid, in_ready, out_c0, out_c1, c0s, c1s);
            end
        end
        in_valid   = 1'b0;
        force_done = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        out_ready  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || core_p0 !== cur_p0) begin
            errors++;
            $display("FAIL stall_ignored: got r=%b v=%b p0=%h want 1 0 %h",
                     in_ready, out_valid, core_p0, cur_p0);
        end
    endtask

    task automatic test_reset_mid_run();
        int   n;
        bit   seen;
        bit   stab;
        exp_t x;
        stub_lat = 20;
        send(1'b1, 64'hA5A5A5A5_5A5A5A5A, 64'h0F0F0F0F_F0F0F0F0,
             128'h1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (core_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_en: got %b want 1", core_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (core_rst !== 1'b1) begin
            errors++;
            $display("FAIL mid_core_rst: got %b want 1", core_rst);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (in_ready !== 1'b1 || core_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle: got r=%b en=%b v=%b want 1 0 0",
                     in_ready, core_en, out_valid);
        end
        stub_lat = 4;
        send(1'b0, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_out(TO + 20, n, seen, stab);
        x = exp_q.pop_front();
        checks++;
        if (!seen || n != 5 || (out_c0 ^ out_c1) !== x.c ||
            out_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_recover: got seen=%b run=%0d %h err=%b want 1 5 %h 0",
                     seen, n, out_c0 ^ out_c1, out_err, x.c);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_done_at_timeout();
        int   n;
        bit   seen;
        bit   stab;
        exp_t x;
        stub_lat = TO;
        send(1'b1, 64'h0011223344556677, 64'h8899AABBCCDDEEFF,
             128'hFEDCBA98_76543210_01234567_89ABCDEF, 1'b0);
        wait_out(TO + 20, n, seen, stab);
        x = exp_q.pop_front();
        checks++;
        if (!seen || n != TO + 1) begin
            errors++;
            $display("FAIL edge_latency: got seen=%b run=%0d want 1 %0d",
                     seen, n, TO + 1);
        end
        checks++;
        if ((out_c0 ^ out_c1) !== x.c || out_err !== 1'b0 ||
            out_c1 !== sr) begin
            errors++;
            $display("FAIL edge_result: got %h err=%b c1=%h want %h 0 %h",
                     out_c0 ^ out_c1, out_err, out_c1, x.c, sr);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   lats [6] = '{0, 1, 2, 7, TO - 1, TO + 5};
        int   n;
        int   want;
        bit   seen;
        bit   stab;
        bit   to;
        exp_t x;
        force_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_done: got v=%b r=%b want 0 1",
                         out_valid, in_ready);
            end
        end
        force_done = 1'b0;
        out_ready  = 1'b1;
        foreach (lats[i]) begin
            stub_lat = lats[i];
            to       = (lats[i] > TO);
            want     = to ? TO + 1 : lats[i] + 1;
            send(i[0], {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, to);
            wait_out(TO + 20, n, seen, stab);
            x = exp_q.pop_front();
            checks++;
            if (!seen || n != want || !stab) begin
                errors++;
                $display("FAIL b2b_timing[%0d]: got seen=%b run=%0d stab=%b want 1 %0d 1",
                         i, seen, n, stab, want);
            end
            checks++;
            if ((out_c0 ^ out_c1) !== x.c || out_err !== x.err) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got %h err=%b want %h err=%b",
                         i, out_c0 ^ out_c1, out_err, x.c, x.err);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_end: got r=%b pending=%0d want 1 0",
                     in_ready, exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_encrypt_vector();
        test_decrypt_vector();
        test_timeout();
        test_hold_stall();
        test_reset_mid_run();
        test_done_at_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prince_io_ctrl.md
PRINCE_IO_CTRL -- requirements
Module: prince_io_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 63, is the maximum number of RUN cycles allowed before an operation is aborted.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  request present; in_ready  out  1  controller can accept.
REQ-005 in_enc  in  1  1 = encrypt, 0 = decrypt.
REQ-006 in_pt  in  64  unmasked plaintext/ciphertext input.
REQ-007 in_mask  in  64  fresh sharing randomness, sampled on accept.
REQ-008 in_key  in  128  cipher key.
REQ-009 core_rst  out  1  reset to the masked PRINCE core.
REQ-010 core_en  out  1  enable to the core.
REQ-011 core_enc  out  1  direction to the core.
REQ-012 core_p0, core_p1  out  64 each  plaintext shares to the core.
REQ-013 core_k  out  128  key to the core.
REQ-014 core_done  in  1  core completion strobe.
REQ-015 core_c0, core_c1  in  64 each  core output shares.
REQ-016 out_valid  out  1  result available; out_ready  in  1  consumer accepts.
REQ-017 out_c0, out_c1  out  64 each  captured result shares, never recombined.
REQ-018 out_err  out  1  result aborted by timeout.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, HOLD.
REQ-020 IDLE: in_ready=1; in_valid=1 is an accept: register p0=in_pt^in_mask, p1=in_mask, in_key, in_enc; next state LOAD.
REQ-021 LOAD: lasts exactly 1 cycle; core_rst=1, core_en=0; clear cycle counter; next state RUN.
REQ-022 RUN: core_en=1, core_rst=0; counter increments by 1 per cycle, saturating at TIMEOUT.
REQ-023 RUN with core_done=1: capture core_c0/core_c1 into out_c0/out_c1, out_err=0; next state HOLD.
REQ-024 RUN with counter==TIMEOUT and core_done=0: out_c0=out_c1=0, out_err=1; next state HOLD.
REQ-025 core_done and timeout in the same cycle: core_done wins; out_err=0.
REQ-026 HOLD: out_valid=1; out_c0/out_c1/out_err stable; core_en=0; on out_ready=1, next state IDLE.
REQ-027 in_ready SHALL be 0 in LOAD, RUN, and HOLD; in_valid in those states SHALL be ignored.
REQ-028 core_p0/core_p1/core_k/core_enc SHALL be driven from the registered values only and held stable from LOAD until IDLE is re-entered.
REQ-029 out_valid SHALL rise in the cycle after the core_done or timeout cycle, i.e. latency from accept is 2 + core cycles + 1.
REQ-030 No combinational path SHALL exist from in_valid/out_ready to in_ready/out_valid; all outputs are state- or register-driven.
REQ-031 core_done while not in RUN SHALL be ignored.

Reset
REQ-032 rst=1 SHALL force IDLE in the next cycle from any state, including mid-RUN, and SHALL assert core_rst in that same cycle.
REQ-033 Reset values: in_ready=1 (after reset release), core_en=0, out_valid=0, out_err=0, out_c0/out_c1=0, core_p0/core_p1/core_k=0, core_enc=0, counter=0.

Structure
REQ-034 State encoding (2-bit enum) and the TIMEOUT default SHALL live in a shared prince package.
REQ-035 The cycle counter SHALL be a separate sub-module, prince_timeout_cnt (clear, enable, saturate, hit flag).
REQ-036 The sharing XOR and output-capture registers SHALL stay in prince_io_ctrl.

Verification
REQ-037 pt=0x0000000000000000, key=0, enc=1, mask=0x0123456789ABCDEF -> out_c0^out_c1=0x818665AA0D02DFDA, out_err=0.
REQ-038 Same vector with enc=0, in_pt=0x818665AA0D02DFDA -> out_c0^out_c1=0, core_p1 equals mask throughout RUN.
REQ-039 Core stub that never asserts core_done -> out_valid after exactly TIMEOUT+1 RUN cycles, out_err=1, shares 0.
REQ-040 out_ready held 0 for 10 cycles in HOLD -> out_valid and shares stable; in_valid during that time not accepted.
REQ-041 rst pulsed in 3rd RUN cycle -> IDLE next cycle, core_en=0, out_valid=0; new request afterwards completes correctly.
REQ-042 Stub asserting core_done in the cycle counter==TIMEOUT -> shares captured, out_err=0.
